ucsbece154b_branch_resolve: RTL and testbench

Branch resolution and predictor-update stage. It sits downstream of the fetch-stage predictor (BTB + gshare PHT/GHR) and consumes that predictor's per-fetch outputs. It carries each prediction through the Decode and Execute pipeline registers and compares it with the Execute-stage outcome. It then raises the mispredict redirect, drives the predictor's BTB/PHT/GHR write ports, and keeps branch and mispredict performance counters.

---
 rtl/ucsbece154b_branch_resolve_if.sv | 56 +++++
 rtl/ucsbece154b_branch_resolve.sv | 130 +++++++++++++
 tb/tb_ucsbece154b_branch_resolve.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_branch_resolve_if.sv
// Bundle of fetch-side prediction metadata, pipeline control, Execute outcome
// and predictor write-back signals exchanged with the branch resolve stage.
interface ucsbece154b_branch_resolve_if #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
);
  localparam int IW = $clog2(NUM_BTB_ENTRIES);

  // Fetch-stage prediction metadata
  logic [31:0]             pcF_i;
  logic                    BranchTakenF_i;
  logic [31:0]             BTBtargetF_i;
  logic [NUM_GHR_BITS-1:0] PHTreadaddressF_i;

  // Pipeline control
  logic                    StallD_i;
  logic                    FlushD_i;
  logic                    StallE_i;
  logic                    FlushE_i;

  // Execute-stage outcome
  logic [6:0]              opE_i;
  logic                    ActualTakenE_i;
  logic [31:0]             ActualTargetE_i;

  // Redirect, predictor write ports and counters
  logic                    MispredictE_o;
  logic [31:0]             PCredirectE_o;
  logic                    BTBwe_o;
  logic [IW-1:0]           BTBwriteaddress_o;
  logic [31:0]             BTBwritedata_o;
  logic                    PHTwe_o;
  logic                    PHTincrement_o;
  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
  logic                    GHRreset_o;
  logic [31:0]             BranchCount_o;
  logic [31:0]             MispredictCount_o;

  modport master (
    output pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
    output StallD_i, FlushD_i, StallE_i, FlushE_i,
    output opE_i, ActualTakenE_i, ActualTargetE_i,
    input  MispredictE_o, PCredirectE_o, BTBwe_o, BTBwriteaddress_o,
    input  BTBwritedata_o, PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
    input  GHRreset_o, BranchCount_o, MispredictCount_o
  );

  modport slave (
    input  pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
    input  StallD_i, FlushD_i, StallE_i, FlushE_i,
    input  opE_i, ActualTakenE_i, ActualTargetE_i,
    output MispredictE_o, PCredirectE_o, BTBwe_o, BTBwriteaddress_o,
    output BTBwritedata_o, PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
    output GHRreset_o, BranchCount_o, MispredictCount_o
  );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// Branch resolution: carries fetch predictions through D/E, compares them with
// the Execute outcome, drives redirect and predictor updates, counts branches.
module ucsbece154b_branch_resolve #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                         clk,
  input  logic                         reset_i,
  ucsbece154b_branch_resolve_if.slave  br_if
);
  localparam int IW = $clog2(NUM_BTB_ENTRIES);

  localparam logic [6:0] INSTR_BRANCH_OP = 7'b1100011;
  localparam logic [6:0] INSTR_JAL_OP    = 7'b1101111;
  localparam logic [6:0] INSTR_JALR_OP   = 7'b1100111;

  typedef struct packed {
    logic                    valid;
    logic [31:0]             pc;
    logic                    pred_taken;
    logic [31:0]             pred_target;
    logic [NUM_GHR_BITS-1:0] pht_addr;
  } meta_t;

  meta_t       r_d;
  meta_t       r_e;
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  logic        w_is_br;
  logic        w_is_j;
  logic        w_is_ctl;
  logic        w_act_taken;
  logic        w_target_diff;
  logic        w_mispredict;
  logic        w_update_ok;
  logic        w_flush_d;
  logic        w_flush_e;
  logic [31:0] w_pc_plus4;

  // Execute-stage decode and comparison against the carried prediction
  assign w_is_br       = (br_if.opE_i == INSTR_BRANCH_OP);
  assign w_is_j        = (br_if.opE_i == INSTR_JAL_OP) || (br_if.opE_i == INSTR_JALR_OP);
  assign w_is_ctl      = w_is_br | w_is_j;
  assign w_act_taken   = w_is_j | (w_is_br & br_if.ActualTakenE_i);
  assign w_target_diff = (r_e.pred_target != br_if.ActualTargetE_i);
  assign w_pc_plus4    = r_e.pc + 32'd4;

  assign w_mispredict = r_e.valid &
                        ((w_is_ctl & ((r_e.pred_taken != w_act_taken) |
                                      (w_act_taken & w_target_diff))) |
                         (~w_is_ctl & r_e.pred_taken));

  // A stalled instruction stays in E; it updates state only on the cycle it leaves
  assign w_update_ok = r_e.valid & ~br_if.StallE_i;

  assign w_flush_d = br_if.FlushD_i | w_mispredict;
  assign w_flush_e = br_if.FlushE_i | w_mispredict;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset clears valid bits immediately.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_d <= '0;
    end else if (w_flush_d) begin
      r_d <= '0;
    end else if (!br_if.StallD_i) begin
      r_d.valid       <= 1'b1;
      r_d.pc          <= br_if.pcF_i;
      r_d.pred_taken  <= br_if.BranchTakenF_i;
      r_d.pred_target <= br_if.BTBtargetF_i;
      r_d.pht_addr    <= br_if.PHTreadaddressF_i;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_e <= '0;
    end else if (w_flush_e) begin
      r_e <= '0;
    end else if (!br_if.StallE_i) begin
      r_e <= r_d;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_update_ok && w_is_ctl) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_mispredict && !br_if.StallE_i) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  // NOTE: every output gets a default first so no path can infer a latch;
  // an invalid E slot leaves them all at zero.
  always_comb begin
    br_if.MispredictE_o     = 1'b0;
    br_if.PCredirectE_o     = '0;
    br_if.BTBwe_o           = 1'b0;
    br_if.BTBwriteaddress_o = '0;
    br_if.BTBwritedata_o    = '0;
    br_if.PHTwe_o           = 1'b0;
    br_if.PHTincrement_o    = 1'b0;
    br_if.PHTwriteaddress_o = '0;
    br_if.GHRreset_o        = 1'b0;
    if (r_e.valid) begin
      br_if.MispredictE_o     = w_mispredict;
      br_if.PCredirectE_o     = (w_mispredict && w_act_taken) ? br_if.ActualTargetE_i
                                                              : w_pc_plus4;
      br_if.BTBwe_o           = w_update_ok & w_is_ctl & w_act_taken &
                                (~r_e.pred_taken | w_target_diff);
      br_if.BTBwriteaddress_o = r_e.pc[IW+1:2];
      br_if.BTBwritedata_o    = br_if.ActualTargetE_i;
      br_if.PHTwe_o           = w_update_ok & w_is_br;
      br_if.PHTincrement_o    = br_if.ActualTakenE_i;
      br_if.PHTwriteaddress_o = r_e.pht_addr;
      br_if.GHRreset_o        = w_mispredict & w_is_br;
    end
  end

  assign br_if.BranchCount_o     = r_branch_count;
  assign br_if.MispredictCount_o = r_mispredict_count;

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Directed self-checking bench for the branch resolve stage.
module tb_ucsbece154b_branch_resolve;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic clk;
  logic reset_i;
  int   total;
  int   bad;
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) bif ();

  ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .br_if   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch bundle and advance it into E with a harmless opcode.
  task automatic load(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                      input logic [4:0] pht);
    bif.pcF_i = pc; bif.BranchTakenF_i = pt; bif.BTBtargetF_i = tgt;
    bif.PHTreadaddressF_i = pht;
    bif.opE_i = OP_ALUI; bif.ActualTakenE_i = 1'b0; bif.ActualTargetE_i = 32'h0;
    tick();
    tick();
  endtask

  // Clear D and E with the stall held so no counter moves.
  task automatic drain();
    bif.StallE_i = 1'b1; bif.FlushE_i = 1'b1; bif.FlushD_i = 1'b1;
    bif.BranchTakenF_i = 1'b0;
    tick();
    bif.StallE_i = 1'b0; bif.FlushE_i = 1'b0; bif.FlushD_i = 1'b0;
    bif.opE_i = OP_ALUI;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    bif.pcF_i = '0; bif.BranchTakenF_i = 1'b0; bif.BTBtargetF_i = '0;
    bif.PHTreadaddressF_i = '0; bif.StallD_i = 1'b0; bif.FlushD_i = 1'b0;
    bif.StallE_i = 1'b0; bif.FlushE_i = 1'b0; bif.opE_i = OP_ALUI;
    bif.ActualTakenE_i = 1'b0; bif.ActualTargetE_i = '0;
    tick();
    #1 reset_i = 1'b0;
    total++; if (bif.MispredictE_o !== 1'b0) begin bad++; $display("FAIL rst_mispredict got=%0h exp=0", bif.MispredictE_o); end
    total++; if (bif.PCredirectE_o !== 32'h0) begin bad++; $display("FAIL rst_redirect got=%0h exp=0", bif.PCredirectE_o); end
    total++; if (bif.BranchCount_o !== 32'h0) begin bad++; $display("FAIL rst_bcount got=%0h exp=0", bif.BranchCount_o); end
    total++; if (bif.MispredictCount_o !== 32'h0) begin bad++; $display("FAIL rst_mcount got=%0h exp=0", bif.MispredictCount_o); end
    total++; if (dut.r_e.valid !== 1'b0) begin bad++; $display("FAIL rst_evalid got=%0h exp=0", dut.r_e.valid); end
    exp_bc = 0; exp_mc = 0;
  endtask

  task automatic test_correct_not_taken();
    load(32'h100, 1'b0, 32'h0, 5'h0A);
    bif.opE_i = OP_BR; bif.ActualTakenE_i = 1'b0; bif.ActualTargetE_i = 32'h104;
    #1;
    total++; if (bif.MispredictE_o !== 1'b0) begin bad++; $display("FAIL cnt_mispredict got=%0h exp=0", bif.MispredictE_o); end
    total++; if (bif.PHTwe_o !== 1'b1) begin bad++; $display("FAIL cnt_phtwe got=%0h exp=1", bif.PHTwe_o); end
    total++; if (bif.PHTincrement_o !== 1'b0) begin bad++; $display("FAIL cnt_phtinc got=%0h exp=0", bif.PHTincrement_o); end
    total++; if (bif.PHTwriteaddress_o !== 5'h0A) begin bad++; $display("FAIL cnt_phtaddr got=%0h exp=a", bif.PHTwriteaddress_o); end
    total++; if (bif.BTBwe_o !== 1'b0) begin bad++; $display("FAIL cnt_btbwe got=%0h exp=0", bif.BTBwe_o); end
    total++; if (bif.BranchCount_o !== 32'd0) begin bad++; $display("FAIL cnt_bcount0 got=%0h exp=0", bif.BranchCount_o); end
    tick(); exp_bc++;
    total++; if (bif.BranchCount_o !== exp_bc) begin bad++; $display("FAIL cnt_bcount1 got=%0h exp=%0h", bif.BranchCount_o, exp_bc); end
    drain();
  endtask

  task automatic test_mispredict_taken();
    load(32'h200, 1'b0, 32'h0, 5'h11);
    bif.opE_i = OP_BR; bif.ActualTakenE_i = 1'b1; bif.ActualTargetE_i = 32'h180;
    #1;
    total++; if (bif.MispredictE_o !== 1'b1) begin bad++; $display("FAIL mt_mispredict got=%0h exp=1", bif.MispredictE_o); end
    total++; if (bif.PCredirectE_o !== 32'h180) begin bad++; $display("FAIL mt_redirect got=%0h exp=180", bif.PCredirectE_o); end
    total++; if (bif.BTBwe_o !== 1'b1) begin bad++; $display("FAIL mt_btbwe got=%0h exp=1", bif.BTBwe_o); end
    total++; if (bif.BTBwriteaddress_o !== 5'h00) begin bad++; $display("FAIL mt_btbaddr got=%0h exp=0", bif.BTBwriteaddress_o); end
    total++; if (bif.BTBwritedata_o !== 32'h180) begin bad++; $display("FAIL mt_btbdata got=%0h exp=180", bif.BTBwritedata_o); end
    total++; if (bif.GHRreset_o !== 1'b1) begin bad++; $display("FAIL mt_ghrreset got=%0h exp=1", bif.GHRreset_o); end
    total++; if (bif.PHTincrement_o !== 1'b1) begin bad++; $display("FAIL mt_phtinc got=%0h exp=1", bif.PHTincrement_o); end
    tick(); exp_bc++; exp_mc++;
    total++; if (dut.r_d.valid !== 1'b0) begin bad++; $display("FAIL mt_dvalid got=%0h exp=0", dut.r_d.valid); end
    total++; if (dut.r_e.valid !== 1'b0) begin bad++; $display("FAIL mt_evalid got=%0h exp=0", dut.r_e.valid); end
    total++; if (bif.MispredictCount_o !== exp_mc) begin bad++; $display("FAIL mt_mcount got=%0h exp=%0h", bif.MispredictCount_o, exp_mc); end
    total++; if (bif.BranchCount_o !== exp_bc) begin bad++; $display("FAIL mt_bcount got=%0h exp=%0h", bif.BranchCount_o, exp_bc); end
    total++; if (bif.MispredictE_o !== 1'b0) begin bad++; $display("FAIL mt_after got=%0h exp=0", bif.MispredictE_o); end
    drain();
  endtask

  task automatic test_stale_target();
    load(32'h40, 1'b1, 32'h80, 5'h03);
    bif.opE_i = OP_JAL; bif.ActualTakenE_i = 1'b0; bif.ActualTargetE_i = 32'h90;
    #1;
    total++; if (bif.MispredictE_o !== 1'b1) begin bad++; $display("FAIL st_mispredict got=%0h exp=1", bif.MispredictE_o); end
    total++; if (bif.PCredirectE_o !== 32'h90) begin bad++; $display("FAIL st_redirect got=%0h exp=90", bif.PCredirectE_o); end
    total++; if (bif.BTBwe_o !== 1'b1) begin bad++; $display("FAIL st_btbwe got=%0h exp=1", bif.BTBwe_o); end
    total++; if (bif.BTBwriteaddress_o !== 5'h10) begin bad++; $display("FAIL st_btbaddr got=%0h exp=10", bif.BTBwriteaddress_o); end
    total++; if (bif.GHRreset_o !== 1'b0) begin bad++; $display("FAIL st_ghrreset got=%0h exp=0", bif.GHRreset_o); end
    total++; if (bif.PHTwe_o !== 1'b0) begin bad++; $display("FAIL st_phtwe got=%0h exp=0", bif.PHTwe_o); end
    tick(); exp_bc++; exp_mc++;
    total++; if (bif.MispredictCount_o !== exp_mc) begin bad++; $display("FAIL st_mcount got=%0h exp=%0h", bif.MispredictCount_o, exp_mc); end
    drain();
  endtask

  task automatic test_alias();
    load(32'h44, 1'b1, 32'h50, 5'h04);
    bif.opE_i = OP_ALU;
    #1;
    total++; if (bif.MispredictE_o !== 1'b1) begin bad++; $display("FAIL al_mispredict got=%0h exp=1", bif.MispredictE_o); end
    total++; if (bif.PCredirectE_o !== 32'h48) begin bad++; $display("FAIL al_redirect got=%0h exp=48", bif.PCredirectE_o); end
    total++; if (bif.BTBwe_o !== 1'b0) begin bad++; $display("FAIL al_btbwe got=%0h exp=0", bif.BTBwe_o); end
    total++; if (bif.PHTwe_o !== 1'b0) begin bad++; $display("FAIL al_phtwe got=%0h exp=0", bif.PHTwe_o); end
    tick(); exp_mc++;
    total++; if (bif.BranchCount_o !== exp_bc) begin bad++; $display("FAIL al_bcount got=%0h exp=%0h", bif.BranchCount_o, exp_bc); end
    total++; if (bif.MispredictCount_o !== exp_mc) begin bad++; $display("FAIL al_mcount got=%0h exp=%0h", bif.MispredictCount_o, exp_mc); end
    drain();
    // Fall-through address wraps past the top of the address space
    load(32'hFFFF_FFFC, 1'b1, 32'h50, 5'h04);
    bif.opE_i = OP_ALU;
    #1;
    total++; if (bif.PCredirectE_o !== 32'h0) begin bad++; $display("FAIL al_wrap got=%0h exp=0", bif.PCredirectE_o); end
    drain();
  endtask

  task automatic test_correct_taken();
    load(32'h300, 1'b1, 32'h380, 5'h07);
    bif.opE_i = OP_BR; bif.ActualTakenE_i = 1'b1; bif.ActualTargetE_i = 32'h380;
    #1;
    total++; if (bif.MispredictE_o !== 1'b0) begin bad++; $display("FAIL ct_mispredict got=%0h exp=0", bif.MispredictE_o); end
    total++; if (bif.BTBwe_o !== 1'b0) begin bad++; $display("FAIL ct_btbwe got=%0h exp=0", bif.BTBwe_o); end
    total++; if (bif.PCredirectE_o !== 32'h304) begin bad++; $display("FAIL ct_redirect got=%0h exp=304", bif.PCredirectE_o); end
    total++; if (bif.PHTincrement_o !== 1'b1) begin bad++; $display("FAIL ct_phtinc got=%0h exp=1", bif.PHTincrement_o); end
    tick(); exp_bc++;
    total++; if (bif.BranchCount_o !== exp_bc) begin bad++; $display("FAIL ct_bcount got=%0h exp=%0h", bif.BranchCount_o, exp_bc); end
    drain();
  endtask

  task automatic test_jalr_top_index();
    load(32'h7C, 1'b0, 32'h0, 5'h02);
    bif.opE_i = OP_JALR; bif.ActualTargetE_i = 32'h1000;
    #1;
    total++; if (bif.BTBwriteaddress_o !== 5'h1F) begin bad++; $display("FAIL jr_btbaddr got=%0h exp=1f", bif.BTBwriteaddress_o); end
    total++; if (bif.PCredirectE_o !== 32'h1000) begin bad++; $display("FAIL jr_redirect got=%0h exp=1000", bif.PCredirectE_o); end
    total++; if (bif.GHRreset_o !== 1'b0) begin bad++; $display("FAIL jr_ghrreset got=%0h exp=0", bif.GHRreset_o); end
    tick(); exp_bc++; exp_mc++;
    total++; if (bif.MispredictCount_o !== exp_mc) begin bad++; $display("FAIL jr_mcount got=%0h exp=%0h", bif.MispredictCount_o, exp_mc); end
    drain();
  endtask

  task automatic test_stall();
    load(32'h500, 1'b0, 32'h0, 5'h1F);
    bif.opE_i = OP_BR; bif.ActualTakenE_i = 1'b0; bif.ActualTargetE_i = 32'h504;
    bif.StallE_i = 1'b1; bif.StallD_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bif.PHTwe_o !== 1'b0) begin bad++; $display("FAIL sx_phtwe cyc=%0d got=%0h exp=0", i, bif.PHTwe_o); end
      tick();
      total++; if (bif.BranchCount_o !== exp_bc) begin bad++; $display("FAIL sx_bcount cyc=%0d got=%0h exp=%0h", i, bif.BranchCount_o, exp_bc); end
    end
    bif.StallE_i = 1'b0; bif.StallD_i = 1'b0;
    #1;
    total++; if (bif.PHTwe_o !== 1'b1) begin bad++; $display("FAIL sx_release got=%0h exp=1", bif.PHTwe_o); end
    tick(); exp_bc++;
    total++; if (bif.BranchCount_o !== exp_bc) begin bad++; $display("FAIL sx_bcount_rel got=%0h exp=%0h", bif.BranchCount_o, exp_bc); end
    bif.StallE_i = 1'b1; bif.FlushE_i = 1'b1;
    tick();
    total++; if (dut.r_e.valid !== 1'b0) begin bad++; $display("FAIL sx_flush_evalid got=%0h exp=0", dut.r_e.valid); end
    total++; if (bif.BranchCount_o !== exp_bc) begin bad++; $display("FAIL sx_bcount_fl got=%0h exp=%0h", bif.BranchCount_o, exp_bc); end
    bif.StallE_i = 1'b0; bif.FlushE_i = 1'b0;
    drain();
  endtask

  task automatic test_mispredict_stall();
    load(32'h600, 1'b0, 32'h0, 5'h08);
    bif.opE_i = OP_BR; bif.ActualTakenE_i = 1'b1; bif.ActualTargetE_i = 32'h700;
    bif.StallE_i = 1'b1; bif.StallD_i = 1'b1;
    #1;
    total++; if (bif.MispredictE_o !== 1'b1) begin bad++; $display("FAIL ms_mispredict got=%0h exp=1", bif.MispredictE_o); end
    total++; if (bif.BTBwe_o !== 1'b0) begin bad++; $display("FAIL ms_btbwe got=%0h exp=0", bif.BTBwe_o); end
    tick();
    total++; if (dut.r_d.valid !== 1'b0) begin bad++; $display("FAIL ms_dvalid got=%0h exp=0", dut.r_d.valid); end
    total++; if (dut.r_e.valid !== 1'b0) begin bad++; $display("FAIL ms_evalid got=%0h exp=0", dut.r_e.valid); end
    total++; if (bif.MispredictCount_o !== exp_mc) begin bad++; $display("FAIL ms_mcount got=%0h exp=%0h", bif.MispredictCount_o, exp_mc); end
    bif.StallE_i = 1'b0; bif.StallD_i = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    load(32'h800, 1'b1, 32'h900, 5'h01);
    total++; if (bif.MispredictE_o !== 1'b1) begin bad++; $display("FAIL rm_pre got=%0h exp=1", bif.MispredictE_o); end
    #2 reset_i = 1'b1;
    #1;
    total++; if (bif.MispredictE_o !== 1'b0) begin bad++; $display("FAIL rm_mispredict got=%0h exp=0", bif.MispredictE_o); end
    total++; if (bif.PCredirectE_o !== 32'h0) begin bad++; $display("FAIL rm_redirect got=%0h exp=0", bif.PCredirectE_o); end
    total++; if (bif.BranchCount_o !== 32'h0) begin bad++; $display("FAIL rm_bcount got=%0h exp=0", bif.BranchCount_o); end
    total++; if (bif.MispredictCount_o !== 32'h0) begin bad++; $display("FAIL rm_mcount got=%0h exp=0", bif.MispredictCount_o); end
    total++; if (dut.r_d.valid !== 1'b0) begin bad++; $display("FAIL rm_dvalid got=%0h exp=0", dut.r_d.valid); end
    total++; if (dut.r_e.valid !== 1'b0) begin bad++; $display("FAIL rm_evalid got=%0h exp=0", dut.r_e.valid); end
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; exp_bc = 0; exp_mc = 0;
    test_reset();
    test_correct_not_taken();
    test_mispredict_taken();
    test_stale_target();
    test_alias();
    test_correct_taken();
    test_jalr_top_index();
    test_stall();
    test_mispredict_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
